imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Sequencer and arbiter for the byte-wide, single-port instruction memory (256 x 8, asynchronous read). It shares the memory between two requesters: the fetch stage and the program loader/debug port. Each fetch is turned into two sequential byte reads assembled big-endian into a 16-bit instruction. Loader byte reads and writes are interleaved fairly with fetches.

## Interface
- MEM_DEPTH, 256: bytes in the instruction memory; legal byte indices 0..MEM_DEPTH-1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch request.
- f_addr  in  16  fetch byte address; instruction occupies f_addr and f_addr+1.
- f_ready  out  1  fetch accepted this cycle (handshake = f_valid & f_ready).
- f_rvalid  out  1  one-cycle fetch response pulse.
- f_rdata  out  16  {mem[a], mem[a+1]}; 0 on error.
- f_err  out  1  qualifies f_rvalid; address out of range.
- l_valid  in  1  loader request.
- l_we  in  1  1 = byte write, 0 = byte read.
- l_addr  in  16  loader byte address.
- l_wdata  in  8  write byte.
- l_ready  out  1  loader accepted this cycle.
- l_rvalid  out  1  one-cycle loader response pulse, for both reads and writes.
- l_rdata  out  8  read byte; 0 for writes and errors.
- l_err  out  1  qualifies l_rvalid; address out of range.
- mem_addr  out  8  memory byte index.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; combinational from mem_addr.

## Operation
- States: IDLE, RD_HI, RD_LO, LD_ACC, ERR_F, ERR_L.
- IDLE: f_ready and l_ready are combinational and are asserted only in IDLE, at most one at a time.
  - Single requester: that requester is granted.
  - Both valid: the requester not granted last time is granted.
  - last_gnt resets to LOADER, so fetch wins the first tie. last_gnt updates on every handshake.
- On handshake, latch the address, l_we and l_wdata.
- Fetch with f_addr > MEM_DEPTH-2 (including f_addr[15:8] != 0, and 0x00FF) goes to ERR_F. There is no memory access.
- Loader with l_addr > MEM_DEPTH-1 goes to ERR_L. There is no memory access and no write.
- RD_HI: mem_addr = a[7:0]; capture mem_rdata into hi; go to RD_LO.
- RD_LO: mem_addr = a[7:0]+1; register f_rdata = {hi, mem_rdata} and pulse f_rvalid; go to IDLE.
- LD_ACC: mem_addr = a[7:0].
  - Write: mem_we = 1, mem_wdata = latched byte; l_rdata = 0.
  - Read: l_rdata = mem_rdata.
  - Pulse l_rvalid; go to IDLE.
- ERR_F / ERR_L: pulse the matching rvalid with err = 1 and rdata = 0; go to IDLE.
- mem_we is high only in LD_ACC with a write latched.
- In IDLE and ERR states: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Requester rules:
  - A requester holds valid and its fields stable until ready.
  - Dropping valid before ready is legal and discards the request.
  - Fields are not sampled after the handshake.

## Timing
- Reset (asynchronous, immediate): state = IDLE, last_gnt = LOADER, all registered outputs 0, mem_we = 0 at once.
- Reset mid-operation: any in-flight response is lost and no pulse follows.
- Handshake at edge E0:
  - Fetch: f_rvalid is high in the cycle after E2 (3-cycle latency).
  - Loader: l_rvalid is high in the cycle after E1.
  - Error: the response is high in the cycle after E1.
- Responses are registered. The response cycle is an IDLE cycle, so a new handshake can occur in it.
- Peak throughput: 3 cycles per fetch, 2 cycles per loader access.
- Loader write at E1 is visible to any later access. A fetch granted after it reads the new byte.
- No combinational path from f_valid or l_valid to mem_*.

## Test plan
Bench memory model init: even byte i = 0x00, odd byte i = i>>1.

- Fetch f_addr = 0x0010: f_ready in the request cycle; f_rvalid 3 cycles later with f_rdata = 0x0008, f_err = 0.
- Odd-address fetch 0x0011: f_rdata = 0x0800. Boundary fetch 0x00FE: f_rdata = 0x007F.
- Loader write 0x0020 <- 0xAB, then fetch 0x0020: l_rvalid after 2 cycles with l_rdata = 0. Fetch returns 0xAB10. A loader read of 0x0020 returns 0xAB.
- Contention: f_valid and l_valid held high with continuous requests from reset.
  - Grants alternate F, L, F, L.
  - mem_we is never asserted outside LD_ACC.
  - No response is dropped or duplicated.
- Errors:
  - Fetch 0x00FF gives f_rvalid with f_err = 1, f_rdata = 0, 2 cycles after handshake.
  - Fetch 0x0100 behaves the same.
  - Loader write to 0x1234 gives l_err = 1, mem_we never asserted, memory unchanged.
- Assert rst_n low during RD_LO:
  - Outputs go to 0 immediately.
  - No f_rvalid pulse follows.
  - After release, the first tie is granted to fetch.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and memory signals of the imem port arbiter
interface imem_port_arbiter_if;
    logic        f_valid;
    logic [15:0] f_addr;
    logic        f_ready;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        f_err;

    logic        l_valid;
    logic        l_we;
    logic [15:0] l_addr;
    logic [7:0]  l_wdata;
    logic        l_ready;
    logic        l_rvalid;
    logic [7:0]  l_rdata;
    logic        l_err;

    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
        output f_ready, f_rvalid, f_rdata, f_err,
        output l_ready, l_rvalid, l_rdata, l_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
        input  f_ready, f_rvalid, f_rdata, f_err,
        input  l_ready, l_rvalid, l_rdata, l_err,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fair sequencer sharing a byte-wide imem between fetch and loader
module imem_port_arbiter #(
    parameter int MEM_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, LD_ACC, ERR_F, ERR_L} state_t;
    typedef enum logic {GNT_FETCH, GNT_LOADER} gnt_t;

    localparam logic [16:0] F_LAST = 17'(MEM_DEPTH - 2);
    localparam logic [16:0] L_LAST = 17'(MEM_DEPTH - 1);

    state_t      state, state_d;
    gnt_t        last_gnt;
    logic [7:0]  addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  hi_q;

    logic        f_rvalid_q, l_rvalid_q, f_err_q, l_err_q;
    logic [15:0] f_rdata_q;
    logic [7:0]  l_rdata_q;

    logic        f_ready_c, l_ready_c, mem_we_c;
    logic [7:0]  mem_addr_c, mem_wdata_c;
    logic        f_grant, l_grant, f_bad, l_bad, f_hs, l_hs;

    // Round-robin tie break: whoever did not win last time wins a tie.
    assign f_grant = bus.f_valid & (~bus.l_valid | (last_gnt == GNT_LOADER));
    assign l_grant = bus.l_valid & (~bus.f_valid | (last_gnt == GNT_FETCH));
    assign f_bad   = {1'b0, bus.f_addr} > F_LAST;
    assign l_bad   = {1'b0, bus.l_addr} > L_LAST;
    assign f_hs    = bus.f_valid & f_ready_c;
    assign l_hs    = bus.l_valid & l_ready_c;

    always_comb begin
        state_d     = state;
        f_ready_c   = 1'b0;
        l_ready_c   = 1'b0;
        mem_addr_c  = '0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        case (state)
            IDLE: begin
                f_ready_c = f_grant;
                l_ready_c = l_grant;
                if (f_grant)      state_d = f_bad ? ERR_F : RD_HI;
                else if (l_grant) state_d = l_bad ? ERR_L : LD_ACC;
            end
            RD_HI: begin
                mem_addr_c = addr_q;
                state_d    = RD_LO;
            end
            RD_LO: begin
                mem_addr_c = addr_q + 8'd1;
                state_d    = IDLE;
            end
            LD_ACC: begin
                mem_addr_c  = addr_q;
                mem_we_c    = we_q;
                mem_wdata_c = we_q ? wdata_q : 8'd0;
                state_d     = IDLE;
            end
            ERR_F, ERR_L: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_gnt   <= GNT_LOADER;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            hi_q       <= '0;
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            f_err_q    <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_rdata_q  <= '0;
            l_err_q    <= 1'b0;
        end else begin
            state      <= state_d;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            if (f_hs) begin
                addr_q   <= bus.f_addr[7:0];
                last_gnt <= GNT_FETCH;
            end else if (l_hs) begin
                addr_q   <= bus.l_addr[7:0];
                we_q     <= bus.l_we;
                wdata_q  <= bus.l_wdata;
                last_gnt <= GNT_LOADER;
            end
            case (state)
                RD_HI: hi_q <= bus.mem_rdata;
                RD_LO: begin
                    f_rvalid_q <= 1'b1;
                    f_rdata_q  <= {hi_q, bus.mem_rdata};
                    f_err_q    <= 1'b0;
                end
                LD_ACC: begin
                    l_rvalid_q <= 1'b1;
                    l_rdata_q  <= we_q ? 8'd0 : bus.mem_rdata;
                    l_err_q    <= 1'b0;
                end
                ERR_F: begin
                    f_rvalid_q <= 1'b1;
                    f_rdata_q  <= '0;
                    f_err_q    <= 1'b1;
                end
                ERR_L: begin
                    l_rvalid_q <= 1'b1;
                    l_rdata_q  <= '0;
                    l_err_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.f_ready   = f_ready_c;
    assign bus.l_ready   = l_ready_c;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.f_err     = f_err_q;
    assign bus.l_rvalid  = l_rvalid_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.l_err     = l_err_q;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if bus();
    imem_port_arbiter #(.MEM_DEPTH(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic run_fetch(input logic [15:0] a, output logic rdy, output int lat,
                             output logic [15:0] d, output logic e);
        @(negedge clk);
        bus.f_valid = 1'b1;
        bus.f_addr  = a;
        #1 rdy = bus.f_ready;
        @(posedge clk);
        #1 bus.f_valid = 1'b0;
        bus.f_addr = '0;
        lat = 0; d = 'x; e = 1'bx;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.f_rvalid) begin lat = i; d = bus.f_rdata; e = bus.f_err; end
        end
    endtask

    task automatic run_load(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            output logic rdy, output int lat, output logic [7:0] d, output logic e);
        @(negedge clk);
        bus.l_valid = 1'b1;
        bus.l_we    = we;
        bus.l_addr  = a;
        bus.l_wdata = wd;
        #1 rdy = bus.l_ready;
        @(posedge clk);
        #1 bus.l_valid = 1'b0;
        bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        lat = 0; d = 'x; e = 1'bx;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.l_rvalid) begin lat = i; d = bus.l_rdata; e = bus.l_err; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.f_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_f_rvalid got %b exp 0", bus.f_rvalid); end
        n_cmp++; if (bus.l_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_l_rvalid got %b exp 0", bus.l_rvalid); end
        n_cmp++; if (bus.f_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_f_rdata got %h exp 0000", bus.f_rdata); end
        n_cmp++; if ({bus.mem_we, bus.mem_addr} !== 9'h0) begin n_bad++; $display("FAIL rst_mem got %h exp 000", {bus.mem_we, bus.mem_addr}); end
        rst_n = 1'b1;
        bus.l_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.f_ready, bus.l_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_lone_loader_grant got %b exp 01", {bus.f_ready, bus.l_ready}); end
        bus.l_valid = 1'b0;
    endtask

    task automatic test_fetch;
        logic rdy; int lat; logic [15:0] d; logic e;
        run_fetch(16'h0010, rdy, lat, d, e);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL f10_ready got %b exp 1", rdy); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL f10_latency got %0d exp 3", lat); end
        n_cmp++; if (d !== 16'h0008) begin n_bad++; $display("FAIL f10_rdata got %h exp 0008", d); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL f10_err got %b exp 0", e); end
        @(negedge clk);
        n_cmp++; if (bus.f_rvalid !== 1'b0) begin n_bad++; $display("FAIL f10_pulse_width got %b exp 0", bus.f_rvalid); end
        run_fetch(16'h0011, rdy, lat, d, e);
        n_cmp++; if (d !== 16'h0800) begin n_bad++; $display("FAIL f11_rdata got %h exp 0800", d); end
        run_fetch(16'h00FE, rdy, lat, d, e);
        n_cmp++; if ({lat, d, e} !== {32'd3, 16'h007F, 1'b0}) begin n_bad++; $display("FAIL ffe_resp got lat %0d data %h err %b exp lat 3 data 007f err 0", lat, d, e); end
    endtask

    task automatic test_loader;
        logic rdy; int lat; logic [7:0] d8; logic [15:0] d; logic e;
        run_load(1'b1, 16'h0020, 8'hAB, rdy, lat, d8, e);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL lw20_ready got %b exp 1", rdy); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw20_latency got %0d exp 2", lat); end
        n_cmp++; if ({d8, e} !== 9'h000) begin n_bad++; $display("FAIL lw20_resp got data %h err %b exp 00 0", d8, e); end
        run_fetch(16'h0020, rdy, lat, d, e);
        n_cmp++; if (d !== 16'hAB10) begin n_bad++; $display("FAIL f20_after_write got %h exp ab10", d); end
        run_load(1'b0, 16'h0020, 8'h00, rdy, lat, d8, e);
        n_cmp++; if ({lat, d8, e} !== {32'd2, 8'hAB, 1'b0}) begin n_bad++; $display("FAIL lr20_resp got lat %0d data %h err %b exp lat 2 data ab err 0", lat, d8, e); end
    endtask

    task automatic test_errors;
        logic rdy; int lat; logic [7:0] d8; logic [15:0] d; logic e; int we0;
        run_fetch(16'h00FF, rdy, lat, d, e);
        n_cmp++; if ({lat, d, e} !== {32'd2, 16'h0000, 1'b1}) begin n_bad++; $display("FAIL fff_err got lat %0d data %h err %b exp lat 2 data 0000 err 1", lat, d, e); end
        run_fetch(16'h0100, rdy, lat, d, e);
        n_cmp++; if ({lat, d, e} !== {32'd2, 16'h0000, 1'b1}) begin n_bad++; $display("FAIL f100_err got lat %0d data %h err %b exp lat 2 data 0000 err 1", lat, d, e); end
        we0 = we_cnt;
        run_load(1'b1, 16'h1234, 8'h77, rdy, lat, d8, e);
        n_cmp++; if ({lat, d8, e} !== {32'd2, 8'h00, 1'b1}) begin n_bad++; $display("FAIL lw1234_err got lat %0d data %h err %b exp lat 2 data 00 err 1", lat, d8, e); end
        n_cmp++; if (we_cnt !== we0) begin n_bad++; $display("FAIL lw1234_mem_we got %0d strobes exp 0", we_cnt - we0); end
        n_cmp++; if (mem[8'h34] !== 8'h00) begin n_bad++; $display("FAIL lw1234_mem34 got %h exp 00", mem[8'h34]); end
    endtask

    task automatic test_contention;
        byte g [$];
        int fr, lr, fg, lg, bad_data, alt_bad, we0;
        fr = 0; lr = 0; fg = 0; lg = 0; bad_data = 0; alt_bad = 0;
        @(negedge clk);
        rst_n = 1'b0;
        bus.f_valid = 1'b1; bus.f_addr = 16'h0010;
        bus.l_valid = 1'b1; bus.l_we = 1'b1; bus.l_addr = 16'h0040; bus.l_wdata = 8'h5A;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we0 = we_cnt;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (bus.f_valid && bus.f_ready) begin g.push_back(byte'("F")); fg++; end
            if (bus.l_valid && bus.l_ready) begin g.push_back(byte'("L")); lg++; end
            if (bus.f_rvalid) begin fr++; if (bus.f_rdata !== 16'h0008 || bus.f_err !== 1'b0) bad_data++; end
            if (bus.l_rvalid) begin lr++; if (bus.l_rdata !== 8'h00 || bus.l_err !== 1'b0) bad_data++; end
            if (c == 19) begin bus.f_valid = 1'b0; bus.l_valid = 1'b0; end
            @(negedge clk);
        end
        for (int i = 0; i < g.size(); i++)
            if (g[i] !== ((i % 2 == 0) ? byte'("F") : byte'("L"))) alt_bad++;
        n_cmp++; if (fg !== 4 || lg !== 4) begin n_bad++; $display("FAIL cont_grant_count got F %0d L %0d exp F 4 L 4", fg, lg); end
        n_cmp++; if (alt_bad !== 0) begin n_bad++; $display("FAIL cont_alternation got %0d out-of-order grants exp 0", alt_bad); end
        n_cmp++; if (fr !== fg || lr !== lg) begin n_bad++; $display("FAIL cont_responses got F %0d L %0d exp F %0d L %0d", fr, lr, fg, lg); end
        n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL cont_resp_data got %0d bad responses exp 0", bad_data); end
        n_cmp++; if (we_cnt - we0 !== lg) begin n_bad++; $display("FAIL cont_mem_we got %0d strobes exp %0d", we_cnt - we0, lg); end
        n_cmp++; if (mem[8'h40] !== 8'h5A) begin n_bad++; $display("FAIL cont_mem40 got %h exp 5a", mem[8'h40]); end
        bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0; bus.f_addr = '0;
    endtask

    task automatic test_reset_midop;
        logic rdy; int lat; logic [15:0] d; logic e; int pulses;
        run_fetch(16'h0011, rdy, lat, d, e);
        @(negedge clk);
        bus.f_valid = 1'b1; bus.f_addr = 16'h0010;
        @(posedge clk);
        #1 bus.f_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.mem_addr !== 8'h11) begin n_bad++; $display("FAIL midop_rd_lo_addr got %h exp 11", bus.mem_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.f_rdata !== 16'h0000) begin n_bad++; $display("FAIL midop_rst_f_rdata got %h exp 0000", bus.f_rdata); end
        n_cmp++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 17'h0) begin n_bad++; $display("FAIL midop_rst_mem got %h exp 00000", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (bus.f_rvalid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midop_no_pulse got %0d pulses exp 0", pulses); end
        bus.f_valid = 1'b1; bus.l_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.f_ready, bus.l_ready} !== 2'b10) begin n_bad++; $display("FAIL midop_first_tie got %b exp 10", {bus.f_ready, bus.l_ready}); end
        bus.f_valid = 1'b0; bus.l_valid = 1'b0;
    endtask

    initial begin
        bus.f_valid = 1'b0; bus.f_addr = '0;
        bus.l_valid = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 1) ? 8'(i >> 1) : 8'h00;
        test_reset();
        test_fetch();
        test_loader();
        test_errors();
        test_contention();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
